// File: rtl/ff_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ff_audio_pkg
// Purpose  : Shared types and constants for the Food Fight stereo 1-bit
//            audio output stage (ff_audio_dac and ff_sigma_delta).
// Contents : audio_state_t  - level-control state machine encoding
//            mid_level()    - midscale code for a given sample width
//            c_default_*    - default build parameters (50 MHz sysclk)
// Revision : 1.0 - initial release
// ============================================================================
package ff_audio_pkg;

    // Default sample width and prescaler (50 MHz / 1024 ~= 48.8 kHz ticks).
    localparam int c_default_width    = 8;
    localparam int c_default_tick_div = 1024;

    // Level-control states. RAMP_UP is entered from reset; the others cover
    // normal playback and the click-free mute/unmute slews.
    typedef enum logic [2:0] {
        RAMP_UP   = 3'd0,
        RUN       = 3'd1,
        MUTE_DOWN = 3'd2,
        MUTED     = 3'd3,
        UNMUTE    = 3'd4
    } audio_state_t;

    // Midscale code of an unsigned sample: 2^(width-1).
    function automatic int mid_level(input int width);
        return 1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff_sigma_delta.sv
`default_nettype none
// ============================================================================
// Module   : ff_sigma_delta
// Purpose  : First-order sigma-delta modulator. Every clock the level is
//            added into a WIDTH-bit accumulator; the carry out of that add
//            is the output bit, so the ones density over any 2^WIDTH
//            consecutive cycles equals level / 2^WIDTH exactly.
// Ports    : clk   - system clock
//            reset - asynchronous, active-high reset (acc and out cleared)
//            level - unsigned level to modulate
//            out   - registered 1-bit stream
// Revision : 1.0 - initial release
// ============================================================================
module ff_sigma_delta #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic             out
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH:0]   w_sum;

    // Extra top bit captures the carry; that carry is the output pulse.
    assign w_sum = {1'b0, r_acc} + {1'b0, level};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            out   <= 1'b0;
        end else begin
            r_acc <= w_sum[WIDTH-1:0];
            out   <= w_sum[WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ff_audio_dac.sv
`default_nettype none
// ============================================================================
// Module   : ff_audio_dac
// Purpose  : Stereo 1-bit audio output stage. Accepts left/right sample
//            pairs over a valid/ready handshake into a one-deep holding
//            register, moves them to the per-channel target once per sample
//            tick, and slews the modulator level on reset and on mute/unmute
//            so the board pins never pop.
// Ports    : clk          - system clock (single clock domain)
//            reset        - asynchronous, active-high reset
//            sample_l/r   - unsigned left/right sample
//            sample_valid - sample pair present
//            sample_ready - holding register empty
//            mute         - 1 = slew to midscale and hold there
//            audio_l/r    - registered sigma-delta bitstreams
// Revision : 1.0 - initial release
// ============================================================================
module ff_audio_dac
    import ff_audio_pkg::*;
#(
    parameter int WIDTH    = c_default_width,
    parameter int TICK_DIV = c_default_tick_div
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_l,
    input  logic [WIDTH-1:0] sample_r,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             mute,
    output logic             audio_l,
    output logic             audio_r
);

    localparam int               c_cnt_w     = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0] c_mid       = WIDTH'(mid_level(WIDTH));
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

    // ------------------------------------------------------------------
    // Sample-rate prescaler
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_count;
    logic               w_tick;

    assign w_tick = (r_count == c_cnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and per-channel target
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_hold_l;
    logic [WIDTH-1:0] r_hold_r;
    logic             r_full;
    logic [WIDTH-1:0] r_target_l;
    logic [WIDTH-1:0] r_target_r;
    logic             w_xfer;
    logic             w_take;
    logic [WIDTH-1:0] w_next_tgt_l;
    logic [WIDTH-1:0] w_next_tgt_r;

    assign sample_ready = ~r_full;
    assign w_xfer       = sample_valid & ~r_full;
    // A load and a take can never coincide: a load needs an empty register,
    // a take needs a full one. A pair loaded on a tick waits one more tick.
    assign w_take       = w_tick & r_full;

    // Target as seen by this tick's level update, so RUN and UNMUTE act on
    // a freshly taken sample without an extra tick of latency.
    assign w_next_tgt_l = w_take ? r_hold_l : r_target_l;
    assign w_next_tgt_r = w_take ? r_hold_r : r_target_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_full     <= 1'b0;
            // Midscale target: an unmute before any sample lands stays quiet.
            r_target_l <= c_mid;
            r_target_r <= c_mid;
        end else if (w_xfer) begin
            r_hold_l <= sample_l;
            r_hold_r <= sample_r;
            r_full   <= 1'b1;
        end else if (w_take) begin
            r_target_l <= r_hold_l;
            r_target_r <= r_hold_r;
            r_full     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Level-control state machine
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] step_toward(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] goal
    );
        if (cur < goal) begin
            return cur + c_one;
        end else if (cur > goal) begin
            return cur - c_one;
        end else begin
            return cur;
        end
    endfunction

    audio_state_t     r_state;
    logic [WIDTH-1:0] r_level_l;
    logic [WIDTH-1:0] r_level_r;
    logic [WIDTH-1:0] w_mid_step_l;
    logic [WIDTH-1:0] w_mid_step_r;
    logic [WIDTH-1:0] w_tgt_step_l;
    logic [WIDTH-1:0] w_tgt_step_r;
    logic             w_mid_done;
    logic             w_tgt_done;

    // One-LSB slews toward midscale (ramp-up and mute) and toward the
    // target (unmute). The "done" flags look at the post-step value so the
    // state changes on the same tick the level arrives.
    assign w_mid_step_l = step_toward(r_level_l, c_mid);
    assign w_mid_step_r = step_toward(r_level_r, c_mid);
    assign w_tgt_step_l = step_toward(r_level_l, w_next_tgt_l);
    assign w_tgt_step_r = step_toward(r_level_r, w_next_tgt_r);
    assign w_mid_done   = (w_mid_step_l == c_mid) && (w_mid_step_r == c_mid);
    assign w_tgt_done   = (w_tgt_step_l == w_next_tgt_l) &&
                          (w_tgt_step_r == w_next_tgt_r);

    // Everything advances on sample ticks only; mute is sampled there. On a
    // tick where a mute change redirects the slew the level is held, so the
    // new direction starts from exactly where the old one stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RAMP_UP;
            r_level_l <= '0;
            r_level_r <= '0;
        end else if (w_tick) begin
            case (r_state)
                RAMP_UP: begin
                    r_level_l <= w_mid_step_l;
                    r_level_r <= w_mid_step_r;
                    if (w_mid_done) begin
                        r_state <= mute ? MUTED : UNMUTE;
                    end
                end
                RUN: begin
                    if (mute) begin
                        r_state <= MUTE_DOWN;
                    end else begin
                        r_level_l <= w_next_tgt_l;
                        r_level_r <= w_next_tgt_r;
                    end
                end
                MUTE_DOWN: begin
                    if (!mute) begin
                        r_state <= UNMUTE;
                    end else begin
                        r_level_l <= w_mid_step_l;
                        r_level_r <= w_mid_step_r;
                        if (w_mid_done) begin
                            r_state <= MUTED;
                        end
                    end
                end
                MUTED: begin
                    // Samples keep draining through the holding register
                    // into target; only the level is pinned.
                    r_level_l <= c_mid;
                    r_level_r <= c_mid;
                    if (!mute) begin
                        r_state <= UNMUTE;
                    end
                end
                UNMUTE: begin
                    if (mute) begin
                        r_state <= MUTE_DOWN;
                    end else begin
                        r_level_l <= w_tgt_step_l;
                        r_level_r <= w_tgt_step_r;
                        if (w_tgt_done) begin
                            r_state <= RUN;
                        end
                    end
                end
                default: begin
                    r_state <= RAMP_UP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Modulators
    // ------------------------------------------------------------------
    ff_sigma_delta #(
        .WIDTH (WIDTH)
    ) u_sd_l (
        .clk   (clk),
        .reset (reset),
        .level (r_level_l),
        .out   (audio_l)
    );

    ff_sigma_delta #(
        .WIDTH (WIDTH)
    ) u_sd_r (
        .clk   (clk),
        .reset (reset),
        .level (r_level_r),
        .out   (audio_r)
    );

endmodule
`default_nettype wire

// File: tb/tb_ff_audio_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_audio_dac
// Purpose  : Self-checking bench for ff_audio_dac (WIDTH=8, TICK_DIV=4).
//            Stimulus pushes the expected sequence of level pairs into a
//            queue; a monitor pops and compares each time the modulator
//            level changes. Output bitstreams, handshake and state are
//            checked directly at phase boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_audio_dac;
    import ff_audio_pkg::*;

    localparam int W  = 8;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sample_l = '0;
    logic [W-1:0] sample_r = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         mute = 1'b0;
    logic         audio_l;
    logic         audio_r;

    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_xfer_cyc = 0;
    logic [15:0]  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ff_audio_dac #(
        .WIDTH    (W),
        .TICK_DIV (TD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .audio_l      (audio_l),
        .audio_r      (audio_r)
    );

    // ---------------------------------------------------------------
    // Monitor: every level change must match the head of the queue.
    // ---------------------------------------------------------------
    initial begin : monitor
        logic [7:0]  prev_l;
        logic [7:0]  prev_r;
        logic [15:0] exp;
        prev_l = '0;
        prev_r = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_l = '0;
                prev_r = '0;
            end else if (dut.r_level_l !== prev_l || dut.r_level_r !== prev_r) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL level_unexpected: got L=%0d R=%0d, required no change from L=%0d R=%0d",
                             dut.r_level_l, dut.r_level_r, prev_l, prev_r);
                end else begin
                    exp = exp_q.pop_front();
                    if ({dut.r_level_l, dut.r_level_r} !== exp) begin
                        n_fail++;
                        $display("FAIL level_seq: got L=%0d R=%0d, required L=%0d R=%0d",
                                 dut.r_level_l, dut.r_level_r, exp[15:8], exp[7:0]);
                    end
                end
                prev_l = dut.r_level_l;
                prev_r = dut.r_level_r;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------
    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic push_pair(input int l, input int r);
        exp_q.push_back({l[7:0], r[7:0]});
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; the handshake completes on the following posedge.
    task automatic send(input int l, input int r, input bit expect_level);
        bit done;
        done = 1'b0;
        sample_l     = l[7:0];
        sample_r     = r[7:0];
        sample_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (sample_ready) begin
                done = 1'b1;
                last_xfer_cyc = cyc;
                if (expect_level) push_pair(l, r);
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("send_accepted", int'(done), 1);
    endtask

    task automatic density(output int ones_l, output int ones_r, output int repeats_l);
        logic prev;
        ones_l    = 0;
        ones_r    = 0;
        repeats_l = 0;
        prev      = audio_l;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ones_l += int'(audio_l);
            ones_r += int'(audio_r);
            if (audio_l == prev) repeats_l++;
            prev = audio_l;
        end
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin : stim
        int ol, orr, rep;
        int t1;

        // Reset values
        wait_cycles(3);
        check("rst_ready", int'(sample_ready), 1);
        check("rst_audio_l", int'(audio_l), 0);
        check("rst_audio_r", int'(audio_r), 0);
        check("rst_level_l", int'(dut.r_level_l), 0);

        // Power-up ramp 1..128, then UNMUTE -> RUN at midscale
        for (int k = 1; k <= 128; k++) push_pair(k, k);
        reset = 1'b0;
        wait_drain("ramp_drain", 700);
        wait_cycles(12);
        check("ramp_state_run", int'(dut.r_state), int'(RUN));
        density(ol, orr, rep);
        check("mid_ones_l", ol, 128);
        check("mid_ones_r", orr, 128);
        check("mid_alternate_l", rep, 0);

        // Full-scale extremes
        send(0, 255, 1'b1);
        wait_drain("extreme_drain", 20);
        wait_cycles(2);
        density(ol, orr, rep);
        check("zero_ones_l", ol, 0);
        check("full_ones_r", orr, 255);

        // Back-to-back stream with valid held high: one transfer per tick
        for (int i = 0; i < 12; i++) begin
            send(10 + 17 * i, 250 - 13 * i, 1'b1);
            if (i == 1) t1 = last_xfer_cyc;
        end
        check("stream_spacing", last_xfer_cyc - t1, 40);
        wait_drain("stream_drain", 20);

        // Mute from RUN at L=200/R=100: slew to midscale, 72 ticks
        send(200, 100, 1'b1);
        wait_drain("pre_mute_drain", 20);
        for (int k = 1; k <= 72; k++) push_pair(200 - k, (100 + k > 128) ? 128 : 100 + k);
        mute = 1'b1;
        wait_drain("mute_drain", 400);
        wait_cycles(8);
        check("muted_state", int'(dut.r_state), int'(MUTED));
        send(60, 90, 1'b0);
        wait_cycles(10);
        check("muted_consumed_ready", int'(sample_ready), 1);
        check("muted_level_l", int'(dut.r_level_l), 128);

        // Unmute: slew to the latest target (60,90), then RUN
        for (int k = 1; k <= 68; k++) push_pair(128 - k, (128 - k < 90) ? 90 : 128 - k);
        mute = 1'b0;
        wait_drain("unmute_drain", 400);
        wait_cycles(8);
        check("unmute_state_run", int'(dut.r_state), int'(RUN));

        // Reverse direction mid-slew at level 150: no jump
        send(200, 200, 1'b1);
        wait_drain("pre_toggle_drain", 20);
        for (int k = 1; k <= 50; k++) push_pair(200 - k, 200 - k);
        mute = 1'b1;
        wait_drain("toggle_down_drain", 300);
        check("toggle_state_mute_down", int'(dut.r_state), int'(MUTE_DOWN));
        for (int k = 151; k <= 200; k++) push_pair(k, k);
        mute = 1'b0;
        wait_drain("toggle_up_drain", 300);
        wait_cycles(8);
        check("toggle_state_run", int'(dut.r_state), int'(RUN));

        // Reset while the holding register is full
        send(77, 33, 1'b0);
        check("pre_reset_full", int'(sample_ready), 0);
        reset = 1'b1;
        #1;
        check("async_reset_ready", int'(sample_ready), 1);
        @(negedge clk);
        check("reset_audio_l", int'(audio_l), 0);
        check("reset_audio_r", int'(audio_r), 0);
        check("reset_level_r", int'(dut.r_level_r), 0);
        check("reset_state", int'(dut.r_state), int'(RAMP_UP));
        wait_cycles(2);
        for (int k = 1; k <= 128; k++) push_pair(k, k);
        reset = 1'b0;
        wait_drain("reramp_drain", 700);
        wait_cycles(20);
        check("reramp_state_run", int'(dut.r_state), int'(RUN));
        check("reramp_level_r", int'(dut.r_level_r), 128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
